// File: rtl/ripple_carry_adder.sv
// Unsigned WIDTH-bit ripple-carry adder built from per-bit full-adder cells, registered output.
// Optional input register stage enabled by defining RIPPLE_CARRY_ADDER_INPUT_REG_EN (latency 2).

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ cin;
    assign cout     = (a & b) | (cin & half_sum);
endmodule

module ripple_carry_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH:0]   SUM
);
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] bit_sum;
    logic [WIDTH:0]   sum_reg;

`ifdef RIPPLE_CARRY_ADDER_INPUT_REG_EN
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            a_reg <= A;
            b_reg <= B;
        end
    end

    assign op_a = a_reg;
    assign op_b = b_reg;
`else
    assign op_a = A;
    assign op_b = B;
`endif

    // Carry enters the chain at bit 0 as zero and ripples upward one cell at a time.
    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            full_adder_cell u_fa (
                .a    (op_a[gi]),
                .b    (op_b[gi]),
                .cin  (carry[gi]),
                .s    (bit_sum[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg <= '0;
        end else begin
            sum_reg <= {carry[WIDTH], bit_sum};
        end
    end

    assign SUM = sum_reg;
endmodule

// File: tb/tb_ripple_carry_adder.sv
// Randomized scoreboard bench for ripple_carry_adder: expected sums are queued as stimulus
// is issued and a separate monitor pops and compares them against SUM every cycle.

module tb_ripple_carry_adder;
    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W:0]   SUM;

    typedef struct {
        bit           chk;
        logic [W:0]   exp;
        logic         r;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Model history: sum of the operands that were accepted at the previous edge.
    logic [W:0] prev_sum   = '0;
    bit         prev_known = 0;

    ripple_carry_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .SUM (SUM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus and queue what SUM must show after the next rising edge.
    task automatic drive(input logic r, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t       e;
        logic [W:0] cur_sum;
        @(negedge clk);
        rst = r;
        A   = a;
        B   = b;
        cur_sum = r ? '0 : ({1'b0, a} + {1'b0, b});
        e.r = r;
        e.a = a;
        e.b = b;
`ifdef RIPPLE_CARRY_ADDER_INPUT_REG_EN
        e.exp = r ? '0 : prev_sum;
        e.chk = r || prev_known;
`else
        e.exp = cur_sum;
        e.chk = 1'b1;
`endif
        prev_sum   = cur_sum;
        prev_known = 1'b1;
        exp_q.push_back(e);
    endtask

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b1, {(W-1){1'b0}}};
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor: SUM is valid every cycle, so one queued expectation is consumed per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    total++;
                    if (SUM !== e.exp) begin
                        bad++;
                        $display("FAIL sum rst=%0b a=%h b=%h got=%h want=%h", e.r, e.a, e.b, SUM, e.exp);
                    end else begin
                        $display("ok   sum rst=%0b a=%h b=%h sum=%h", e.r, e.a, e.b, SUM);
                    end
                end
            end
        end
    end

    initial begin
        logic [W-1:0] va [12];
        logic [W-1:0] vb [12];
        rst = 1'b1;
        A   = '0;
        B   = '0;

        // Reset held with all-ones operands: SUM must stay zero.
        drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);

        va = '{32'h00000001, 32'h0000000F, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF,
               32'hFFFF0000, 32'h12345678, 32'hA5A5A5A5, 32'h00000000, 32'hFFFFFFFF, 32'h00000001};
        vb = '{32'h00000001, 32'h00000010, 32'h00000001, 32'h00000001, 32'h80000000, 32'hFFFFFFFF,
               32'hFFFF0000, 32'hEDCBA987, 32'h5A5A5A5A, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
        for (int i = 0; i < 12; i++) drive(1'b0, va[i], vb[i]);

        // Back-to-back random stream with an explicit reset pulse in the middle.
        for (int i = 0; i < 40; i++) drive(1'b0, rand_operand(), rand_operand());
        drive(1'b1, rand_operand(), rand_operand());
        for (int i = 0; i < 40; i++) drive(1'b0, rand_operand(), rand_operand());
        drive(1'b1, rand_operand(), rand_operand());
        drive(1'b1, rand_operand(), rand_operand());
        for (int i = 0; i < 120; i++) drive(($urandom_range(0, 19) == 0), rand_operand(), rand_operand());

        // Flush the pipeline with a few extra cycles.
        for (int i = 0; i < 3; i++) drive(1'b0, rand_operand(), rand_operand());

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0 pending expectations", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
